rgb_seq_ctrl: RTL and testbench

RGB_SEQ_CTRL -- requirements
Module: rgb_seq_ctrl

---
 rtl/rgb_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_rgb_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_seq_ctrl.sv
// RGB colour sequencer: steps through six colours on a timed RUN schedule or by
// single STEP commands, with a PWM brightness gate on each LED channel.
module rgb_seq_ctrl #(
  parameter int BLINK_INTERVAL = 2000000,
  parameter int PWM_BITS       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [PWM_BITS-1:0] cmd_arg,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                running,
  output logic [2:0]          color_idx
);

  localparam int CNT_W = (BLINK_INTERVAL > 2) ? $clog2(BLINK_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_INTERVAL - 1);

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_LEVEL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                accept;

  // Out-of-range indices (6, 7) fold back to red on the next advance.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] color_bits(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b100;
      3'd1:    return 3'b110;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    level_d = level_q;
    pwm_d   = pwm_q + 1'b1;
    rgb_d   = color_bits(idx_q) & {3{pwm_q < level_q}};
    accept  = cmd_valid && (state_q != STEP);

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_d = RUN;
              cnt_d   = '0;
            end
            OP_STEP: begin
              state_d = STEP;
              idx_d   = next_idx(idx_q);
            end
            OP_LEVEL: level_d = cmd_arg;
            default: ;
          endcase
        end
      end
      RUN: begin
        // STOP wins over a coincident interval expiry: the colour is held.
        if (accept && cmd_op == OP_STOP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = next_idx(idx_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (accept && cmd_op == OP_LEVEL) level_d = cmd_arg;
        end
      end
      STEP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      pwm_q   <= '0;
      level_q <= '1;
      rgb_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      level_q <= level_d;
      rgb_q   <= rgb_d;
    end
  end

  assign cmd_ready = (state_q != STEP);
  assign running   = (state_q == RUN);
  assign color_idx = idx_q;
  assign RGB_R     = rgb_q[2];
  assign RGB_G     = rgb_q[1];
  assign RGB_B     = rgb_q[0];

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Bench for rgb_seq_ctrl: directed scenarios plus random commands, all checked
// against a timeline model (colour = start colour + elapsed cycles / interval).
module tb_rgb_seq_ctrl;
  localparam int BI = 4;
  localparam int PB = 2;
  localparam logic [1:0] OP_RUN = 2'b00, OP_STOP = 2'b01, OP_STEP = 2'b10, OP_LEVEL = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_arg = 2'b00;
  logic       RGB_R, RGB_G, RGB_B, running;
  logic [2:0] color_idx;
  logic [7:0] obs;

  rgb_seq_ctrl #(.BLINK_INTERVAL(BI), .PWM_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .RGB_R(RGB_R), .RGB_G(RGB_G),
    .RGB_B(RGB_B), .running(running), .color_idx(color_idx)
  );

  always #5 clk = ~clk;
  assign obs = {running, cmd_ready, color_idx, RGB_R, RGB_G, RGB_B};

  logic [2:0] colors [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  // Timeline model: edges counted since reset release; while running the colour
  // is the start colour plus the number of whole intervals elapsed since RUN.
  int         m_edges, m_run_edge, m_base, m_level;
  bit         m_running, m_in_step;
  logic [2:0] m_rgb;
  int         checks = 0;
  int         errors = 0;

  function automatic int m_idx();
    if (m_running) return (m_base + (m_edges - m_run_edge) / BI) % 6;
    return m_base;
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [2:0] i3;
    i3 = 3'(m_idx());
    return {m_running, !m_in_step, i3, m_rgb};
  endfunction

  task automatic model_reset();
    m_edges = 0; m_run_edge = 0; m_base = 0; m_level = (1 << PB) - 1;
    m_running = 0; m_in_step = 0; m_rgb = 3'b000;
  endtask

  task automatic tick(input bit v, input logic [1:0] op, input logic [1:0] arg);
    int cur_idx, cur_pwm;
    bit acc;
    cmd_valid = v; cmd_op = op; cmd_arg = arg;
    cur_idx = m_idx();
    cur_pwm = m_edges % (1 << PB);
    acc = v && !m_in_step;
    @(posedge clk);
    m_edges++;
    m_rgb = (cur_pwm < m_level) ? colors[cur_idx] : 3'b000;
    if (m_in_step) m_in_step = 0;
    else if (acc) begin
      case (op)
        OP_RUN:   if (!m_running) begin m_running = 1; m_base = cur_idx; m_run_edge = m_edges; end
        OP_STOP:  if (m_running) begin m_running = 0; m_base = cur_idx; end
        OP_STEP:  if (!m_running) begin m_base = (cur_idx + 1) % 6; m_in_step = 1; end
        default:  m_level = int'(arg);
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs !== 8'b01_000_000) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs, 8'b01_000_000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_run_sequence();
    int changes;
    logic [2:0] prev;
    changes = 0;
    tick(1, OP_RUN, 2'b00);
    prev = color_idx;
    for (int i = 0; i < 6 * BI + 2; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL run_seq cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
      if (color_idx !== prev) changes++;
      prev = color_idx;
    end
    checks++;
    if (changes !== 6) begin
      errors++; $display("FAIL run_seq_advances: got %0d expected %0d", changes, 6);
    end
  endtask

  task automatic test_stop_at_boundary();
    logic [2:0] held;
    for (int i = 0; i < 2 * BI && (m_edges - m_run_edge) % BI != BI - 1; i++)
      tick(0, OP_RUN, 2'b00);
    held = color_idx;
    tick(1, OP_STOP, 2'b00);
    checks++;
    if (obs !== exp_vec() || color_idx !== held || running !== 1'b0) begin
      errors++; $display("FAIL stop_boundary: got %b expected %b (held idx %0d)", obs, exp_vec(), held);
    end
    repeat (3) tick(0, OP_RUN, 2'b00);
    tick(1, OP_RUN, 2'b00);
    for (int i = 0; i < 2 * BI + 1; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL stop_resume cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_step_wrap();
    tick(1, OP_STOP, 2'b00);
    for (int i = 0; i < 12 && m_idx() != 5; i++) begin
      tick(1, OP_STEP, 2'b00);
      tick(0, OP_STEP, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL step_walk %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, OP_STEP, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL step_held %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    checks++;
    if (color_idx !== 3'd1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL step_wrap_final: got idx %0d ready %b expected idx 1 ready 0", color_idx, cmd_ready);
    end
    tick(0, OP_STEP, 2'b00);
  endtask

  task automatic test_set_level();
    int r_on, b_on;
    tick(1, OP_LEVEL, 2'd0);
    for (int i = 0; i < 8; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL level0 cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    tick(1, OP_LEVEL, 2'd2);
    tick(0, OP_RUN, 2'b00);
    r_on = 0; b_on = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL level2 cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
      if (RGB_R === 1'b1 && RGB_G === 1'b1) r_on++;
      if (RGB_B !== 1'b0) b_on++;
    end
    checks++;
    if (r_on !== 4 || b_on !== 0) begin
      errors++; $display("FAIL level2_duty: got rg_on %0d b_on %0d expected 4 and 0", r_on, b_on);
    end
  endtask

  task automatic test_reset_mid_run();
    int r_on;
    tick(1, OP_LEVEL, 2'd1);
    tick(1, OP_RUN, 2'b00);
    for (int i = 0; i < 8 * BI && m_idx() != 3; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL pre_reset cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL async_reset: got %b expected %b", obs, exp_vec());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r_on = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, OP_RUN, 2'b00);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL post_reset cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
      if (RGB_R === 1'b1) r_on++;
    end
    checks++;
    if (r_on !== 6) begin
      errors++; $display("FAIL post_reset_level: got red_on %0d expected 6", r_on);
    end
  endtask

  task automatic test_random();
    bit v;
    logic [1:0] op, arg;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) == 0);
      op  = 2'($urandom_range(0, 3));
      arg = 2'($urandom_range(0, 3));
      tick(v, op, arg);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d (v %0d op %0d arg %0d): got %b expected %b",
                           i, v, op, arg, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_sequence();
    test_stop_at_boundary();
    test_step_wrap();
    test_set_level();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
